// File: rtl/simon_pkg.sv
// Shared definitions for the press recorder: button/address widths, the
// recorder FSM state type and a one-hot test used to flag bad presses.
package simon_pkg;

  localparam int unsigned BTN_W  = 12;
  localparam int unsigned ADDR_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRelease,
    StArmed,
    StDone
  } state_e;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [BTN_W-1:0] v);
    return (v != '0) && ((v & (v - BTN_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/press_ram.sv
// Press storage: 256 x 12 memory with one write port and one synchronous,
// enabled read port. Read data is registered and cleared by reset; the array
// itself is never cleared. A same-address read and write returns old data.
//   clk_i   clock            rst_i   sync active-high reset (read register only)
//   we_i    write enable     waddr_i write address    wdata_i write data
//   re_i    read enable      raddr_i read address     rdata_o registered read data
module press_ram
  import simon_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [BTN_W-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [BTN_W-1:0]  rdata_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [BTN_W-1:0] mem_q [Depth];
  logic [BTN_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Non-blocking update of mem_q gives read-before-write on address collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/press_rec.sv
// Press recorder: after start, records len button presses into press_ram, one
// entry per press (a press must be released before the next one is taken).
//   clk    clock                 rst    sync active-high reset
//   start  begin recording       len    presses to record (sampled on start)
//   btns   debounced buttons     rd_en/rd_sel/rd_data  playback read port
//   count  presses recorded      busy   recording in progress
//   done   recording complete    err    sticky non-one-hot press seen
module press_rec
  import simon_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [BTN_W-1:0]  btns,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_sel,
  output logic [BTN_W-1:0]  rd_data,
  output logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              wr_en;

  // start and rst both discard a press landing in the same cycle.
  always_comb begin
    wr_en = (state_q == StArmed) && (btns != '0) && !start && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (start) begin
      count_q <= '0;
      err_q   <= 1'b0;
      if (len != '0) begin
        len_q    <= len;
        wr_ptr_q <= '0;
        state_q  <= StRelease;
        busy_q   <= 1'b1;
        done_q   <= 1'b0;
      end else begin
        state_q <= StDone;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end else begin
      unique case (state_q)
        StRelease: begin
          if (btns == '0) begin
            state_q <= StArmed;
          end
        end
        StArmed: begin
          if (btns != '0) begin
            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            count_q  <= count_q + ADDR_W'(1);
            if (!is_onehot(btns)) begin
              err_q <= 1'b1;
            end
            if (count_q + ADDR_W'(1) == len_q) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRelease;
            end
          end
        end
        StIdle, StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  press_ram u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (btns),
    .re_i    (rd_en),
    .raddr_i (rd_sel),
    .rdata_o (rd_data)
  );

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_press_rec.sv
module tb_press_rec;

  logic        clk = 1'b0;
  logic        rst, start, rd_en;
  logic [7:0]  len, rd_sel, count;
  logic [11:0] btns, rd_data;
  logic        busy, done, err;

  always #5 clk = ~clk;

  press_rec dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .btns    (btns),
    .rd_en   (rd_en),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: recording described as "active" plus "must see release".
  logic [11:0] m_mem [256];
  bit          m_valid [256];
  bit          m_active, m_need_rel, m_done, m_err;
  int          m_count, m_len, m_wp;
  logic [11:0] m_rd;
  bit          m_rd_known;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit s, input int l, input logic [11:0] b,
                       input bit re, input int rs);
    if (r) begin
      m_active = 0; m_need_rel = 0; m_done = 0; m_err = 0;
      m_count = 0; m_wp = 0; m_rd = '0; m_rd_known = 1;
      return;
    end
    if (re) begin
      m_rd = m_mem[rs];
      m_rd_known = m_valid[rs];
    end
    if (s) begin
      m_count = 0; m_err = 0;
      if (l != 0) begin
        m_len = l; m_wp = 0; m_active = 1; m_need_rel = 1; m_done = 0;
      end else begin
        m_active = 0; m_done = 1;
      end
    end else if (m_active) begin
      if (m_need_rel) begin
        if (b == 0) m_need_rel = 0;
      end else if (b != 0) begin
        m_mem[m_wp] = b;
        m_valid[m_wp] = 1;
        m_wp++;
        m_count++;
        if ($countones(b) != 1) m_err = 1;
        if (m_count == m_len) begin
          m_active = 0; m_done = 1;
        end else begin
          m_need_rel = 1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input int l, input logic [11:0] b,
                      input bit re, input int rs);
    rst = r; start = s; len = 8'(l); btns = b; rd_en = re; rd_sel = 8'(rs);
    model(r, s, l, b, re, rs);
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(m_count));
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("err", 32'(err), 32'(m_err));
    if (m_rd_known) check("rd_data", 32'(rd_data), 32'(m_rd));
  endtask

  task automatic idle(input int n, input logic [11:0] b);
    for (int i = 0; i < n; i++) step(0, 0, 0, b, 0, 0);
  endtask

  task automatic rd(input int a);
    step(0, 0, 0, 12'h000, 1, a);
  endtask

  initial begin
    int hold;
    logic [11:0] cur;
    int pick;
    rst = 1; start = 0; len = 0; btns = 0; rd_en = 0; rd_sel = 0;
    for (int i = 0; i < 256; i++) m_valid[i] = 0;
    m_len = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    check("rst_count", 32'(count), 0);
    check("rst_rd", 32'(rd_data), 0);
    idle(2, 12'h000);

    // Three presses, held 5 cycles, 3 idle between
    step(0, 1, 3, 0, 0, 0);
    idle(3, 12'h000);
    idle(5, 12'h001); idle(3, 12'h000);
    idle(5, 12'h004); idle(3, 12'h000);
    idle(5, 12'h800); idle(3, 12'h000);
    check("s1_count", 32'(count), 3);
    check("s1_done", 32'(done), 1);
    check("s1_busy", 32'(busy), 0);
    rd(0); check("s1_rd0", 32'(rd_data), 32'h001);
    rd(1); check("s1_rd1", 32'(rd_data), 32'h004);
    rd(2); check("s1_rd2", 32'(rd_data), 32'h800);
    idle(2, 12'h000);
    check("s1_rd_hold", 32'(rd_data), 32'h800);

    // Long hold records a single entry
    step(0, 1, 2, 0, 0, 0);
    idle(1, 12'h000);
    idle(50, 12'h002);
    check("s2_count", 32'(count), 1);
    check("s2_busy", 32'(busy), 1);
    idle(2, 12'h000);

    // Button already held at start
    step(0, 1, 1, 12'h010, 0, 0);
    idle(4, 12'h010);
    check("s3_nowrite", 32'(count), 0);
    idle(2, 12'h000);
    idle(3, 12'h020);
    idle(1, 12'h000);
    rd(0); check("s3_rd0", 32'(rd_data), 32'h020);

    // Non-one-hot press sets sticky err
    step(0, 1, 1, 0, 0, 0);
    idle(1, 12'h000);
    idle(2, 12'h003);
    idle(4, 12'h000);
    check("s4_err", 32'(err), 1);
    rd(0); check("s4_rd0", 32'(rd_data), 32'h003);
    step(0, 1, 1, 0, 0, 0);
    check("s4_err_clr", 32'(err), 0);

    // Reset mid-recording keeps memory
    step(0, 1, 4, 0, 0, 0);
    idle(1, 12'h000);
    idle(2, 12'h001); idle(1, 12'h000);
    idle(2, 12'h002); idle(1, 12'h000);
    step(1, 0, 0, 0, 0, 0);
    check("s5_count", 32'(count), 0);
    check("s5_done", 32'(done), 0);
    check("s5_busy", 32'(busy), 0);
    rd(1); check("s5_rd1", 32'(rd_data), 32'h002);

    // len=0 and start colliding with an ARMED press
    step(0, 1, 0, 0, 0, 0);
    check("s6_done", 32'(done), 1);
    check("s6_count", 32'(count), 0);
    step(0, 1, 2, 0, 0, 0);
    idle(1, 12'h000);
    step(0, 1, 2, 12'h040, 0, 0);
    check("s6_nowrite", 32'(count), 0);
    idle(1, 12'h000);
    rd(0); check("s6_rd0", 32'(rd_data), 32'h001);

    // Randomized traffic against the model
    hold = 0;
    cur = '0;
    step(0, 1, 5, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pick = $urandom_range(0, 9);
        if (pick < 4) cur = '0;
        else if (pick < 8) cur = 12'(1) << $urandom_range(0, 11);
        else cur = 12'($urandom_range(0, 4095));
        hold = $urandom_range(1, 6);
      end
      hold--;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
           $urandom_range(0, 5), cur, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/press_rec.md
PRESS_REC -- requirements
Module: press_rec

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all logic.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  one-cycle pulse; begins a new recording of len presses.
REQ-004 SHALL have port: len  input  8  number of presses to record, sampled only when start=1.
REQ-005 SHALL have port: btns  input  12  synchronized, debounced player buttons, one bit per button.
REQ-006 SHALL have port: rd_en  input  1  read enable for the playback/compare port.
REQ-007 SHALL have port: rd_sel  input  8  read address.
REQ-008 SHALL have port: rd_data  output  12  registered read data.
REQ-009 SHALL have port: count  output  8  presses recorded so far in the current recording.
REQ-010 SHALL have port: busy  output  1  high while a recording is in progress.
REQ-011 SHALL have port: done  output  1  high from completion until the next start or rst.
REQ-012 SHALL have port: err  output  1  sticky; set when a recorded pattern has other than exactly one bit set.

Function
REQ-013 SHALL implement FSM states IDLE, RELEASE, ARMED, DONE.
REQ-014 SHALL, on start with len!=0 in any state, latch len, clear count, write pointer and err, and enter RELEASE next cycle.
REQ-015 SHALL, on start with len=0, clear count and err and enter DONE without writing.
REQ-016 SHALL, in RELEASE, move to ARMED on the first cycle btns==0; otherwise stay.
REQ-017 SHALL, in ARMED with btns!=0, write btns to memory[wr_ptr] that cycle, increment wr_ptr and count, and set err if btns is not one-hot.
REQ-018 SHALL, after the write of REQ-017, enter DONE if the new count equals the latched len, else RELEASE.
REQ-019 SHALL record exactly one entry per press, regardless of how long the press is held.
REQ-020 SHALL ignore btns in IDLE and DONE.
REQ-021 SHALL drive busy=1 in RELEASE and ARMED only; done=1 in DONE only.
REQ-022 SHALL give start priority over all other transitions in the same cycle, including an ARMED write, which is discarded.
REQ-023 SHALL, on rd_en=1, load rd_data with memory[rd_sel] at the next clock edge (1-cycle latency); rd_data SHALL hold when rd_en=0.
REQ-024 SHALL return the old contents on a same-cycle read and write to the same address (read-before-write).
REQ-025 SHALL use an 8-bit wr_ptr; the maximum len of 255 prevents wrap-around within one recording.

Reset
REQ-026 SHALL, on rst, enter IDLE and clear count, wr_ptr, rd_data, err, busy and done to 0.
REQ-027 SHALL give rst priority over start.
REQ-028 SHALL NOT clear memory contents on rst.
REQ-029 SHALL discard any recording in progress when rst is asserted during it.

Structure
REQ-030 SHALL take BTN_W=12, ADDR_W=8 and the state enum from shared package simon_pkg.
REQ-031 SHALL place storage in sub-module press_ram: 256x12, one write port, one synchronous read port with enable.

Verification
REQ-032 SHALL cover this scenario: start, len=3; presses 0x001, 0x004, 0x800, each held 5 cycles with 3 idle cycles between -> count=3, done=1, busy=0; reads at 0,1,2 -> 0x001, 0x004, 0x800 one cycle after rd_en.
REQ-033 SHALL cover this scenario: 0x002 held 50 cycles with len=2 -> count=1 and busy=1 after the hold.
REQ-034 SHALL cover this scenario: btns=0x010 already held when start arrives -> no write until release; the next press is stored at address 0.
REQ-035 SHALL cover this scenario: press 0x003 -> stored 0x003, err=1 and sticky until the next start.
REQ-036 SHALL cover this scenario: rst after 2 of 4 presses -> IDLE, count=0, done=0; the earlier memory contents are still readable.
REQ-037 SHALL cover this scenario: start with len=0 -> done=1 and count=0 the next cycle; start coinciding with an ARMED press -> no write, count=0.
